reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 81 ++++++++
 tb/tb_reg_write_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin arbiter that forwards one register-file write per cycle.
// Writes to register 0 are accepted but discarded and counted in a saturating counter.
module reg_write_arbiter #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_data,
   input  logic          req1_valid,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_data,
   output logic          req0_ready,
   output logic          req1_ready,
   output logic          regWrite,
   output logic [AW-1:0] A3,
   output logic [DW-1:0] WD,
   output logic          grant_id,
   output logic [CW-1:0] drop_cnt
);

   logic          lp;
   logic          grant0;
   logic          grant1;
   logic          xfer;
   logic          gid;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;

   // On contention the requester that did not win last time gets the slot.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst) begin
         if (req0_valid && req1_valid) begin
            if (lp) grant0 = 1'b1;
            else    grant1 = 1'b1;
         end else if (req0_valid) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign xfer       = grant0 | grant1;
   assign gid        = grant1;
   assign sel_addr   = grant1 ? req1_addr : req0_addr;
   assign sel_data   = grant1 ? req1_data : req0_data;

   // lp resets to 1 so that req0 wins the first contended cycle after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         regWrite <= 1'b0;
         A3       <= '0;
         WD       <= '0;
         grant_id <= 1'b0;
         drop_cnt <= '0;
         lp       <= 1'b1;
      end else begin
         regWrite <= 1'b0;
         if (xfer) begin
            lp       <= gid;
            grant_id <= gid;
            if (sel_addr != '0) begin
               regWrite <= 1'b1;
               A3       <= sel_addr;
               WD       <= sel_data;
            end else if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: stimulus queues expected writes,
// a negedge monitor compares every cycle's outputs against the queue and a small model.
module tb_reg_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 8;

   logic          clk;
   logic          rst;
   logic          req0_valid;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_data;
   logic          req1_valid;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_data;
   logic          req0_ready;
   logic          req1_ready;
   logic          regWrite;
   logic [AW-1:0] A3;
   logic [DW-1:0] WD;
   logic          grant_id;
   logic [CW-1:0] drop_cnt;

   reg_write_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .regWrite   (regWrite),
      .A3         (A3),
      .WD         (WD),
      .grant_id   (grant_id),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          id;
   } wr_t;

   wr_t           q[$];
   int            compared;
   int            mismatched;
   int            cycle;
   bit            checking;
   bit            expWr;
   logic          expGid;
   logic [CW-1:0] expDrop;
   logic [AW-1:0] holdA3;
   logic [DW-1:0] holdWD;
   int            n0;
   int            n1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // One clock of stimulus; e0/e1 are the hand-derived grants for this cycle.
   task automatic applyStimulus(input logic r,
                                input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic e0, input logic e1);
      logic [AW-1:0] ga;
      logic [DW-1:0] gd;
      rst        = r;
      req0_valid = v0;
      req0_addr  = a0;
      req0_data  = d0;
      req1_valid = v1;
      req1_addr  = a1;
      req1_data  = d1;
      ga = e1 ? a1 : a0;
      gd = e1 ? d1 : d0;
      @(negedge clk);
      checkOutput("req0_ready", req0_ready, e0);
      checkOutput("req1_ready", req1_ready, e1);
      if ((e0 || e1) && ga != '0) q.push_back('{cycle + 1, ga, gd, e1});
      @(posedge clk);
      #1;
      cycle++;
      if (!r) begin
         expGid  = 1'b0;
         expDrop = '0;
         holdA3  = '0;
         holdWD  = '0;
      end else if (e0 || e1) begin
         expGid = e1;
         if (ga == '0 && expDrop != 8'd255) expDrop = expDrop + 8'd1;
      end
   endtask

   // Monitor: each cycle either exactly the queued write appears or the outputs hold.
   always @(negedge clk) begin
      if (checking) begin
         expWr = (q.size() > 0) && (q[0].cyc == cycle);
         checkOutput("regWrite", regWrite, expWr);
         if (expWr) begin
            checkOutput("A3", A3, q[0].a);
            checkOutput("WD", WD, q[0].d);
            checkOutput("write_id", grant_id, q[0].id);
            holdA3 = q[0].a;
            holdWD = q[0].d;
            void'(q.pop_front());
         end else begin
            checkOutput("A3_hold", A3, holdA3);
            checkOutput("WD_hold", WD, holdWD);
         end
         checkOutput("grant_id", grant_id, expGid);
         checkOutput("drop_cnt", drop_cnt, expDrop);
      end
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      cycle      = 0;
      checking   = 0;
      expGid     = 1'b0;
      expDrop    = '0;
      holdA3     = '0;
      holdWD     = '0;
      n0         = 0;
      n1         = 0;

      // Requests present during reset must not be granted.
      applyStimulus(0, 1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222, 0, 0);
      checking = 1;
      applyStimulus(0, 1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222, 0, 0);

      // Both valid right after reset: req0 first, then req1.
      applyStimulus(1, 1, 5'd3, 32'hAAAA0000, 1, 5'd4, 32'h5555, 1, 0);
      applyStimulus(1, 0, 5'd0, 32'h0,        1, 5'd4, 32'h5555, 0, 1);
      applyStimulus(1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 0);

      // Lone req1 streaming to the same address.
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 0, 5'd0, 32'h0, 1, 5'd7, 32'h7000 + i, 0, 1);
      applyStimulus(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);

      // Writes to register 0 are dropped; counter saturates at 255.
      for (int i = 0; i < 300; i++)
         applyStimulus(1, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 0);
      applyStimulus(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);

      // Continuous contention; last grant was req0 so req1 leads.
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) begin
            applyStimulus(1, 1, 5'd10, 32'h1000 + n0, 1, 5'd20, 32'h2000 + n1, 0, 1);
            n1++;
         end else begin
            applyStimulus(1, 1, 5'd10, 32'h1000 + n0, 1, 5'd20, 32'h2000 + n1, 1, 0);
            n0++;
         end
      end

      // Reset mid-stream with both valid; req0 wins first after release.
      applyStimulus(1, 1, 5'd11, 32'hB0, 1, 5'd21, 32'hC0, 0, 1);
      applyStimulus(0, 1, 5'd11, 32'hB0, 1, 5'd22, 32'hC1, 0, 0);
      applyStimulus(1, 1, 5'd11, 32'hB0, 1, 5'd22, 32'hC1, 1, 0);
      applyStimulus(1, 1, 5'd12, 32'hB1, 1, 5'd22, 32'hC1, 0, 1);
      applyStimulus(1, 1, 5'd12, 32'hB1, 0, 5'd0,  32'h0,  1, 0);
      applyStimulus(1, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 0);
      applyStimulus(1, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 0);

      checkOutput("pending_writes", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
